fifo_out_multi: RTL and testbench

Output-side FIFO with AXI-Stream master that accepts up to LANES values per write cycle and drains them one per cycle, in lane order, on AXIS. It generalises the single-value output FIFO: multi-lane writes, arbitrary (non-power-of-two) DEPTH, per-packet TLAST marking and a sticky overflow flag. It sits between the compute datapath, which may produce several results per cycle, and the AXIS output port of the accelerator.

---
 rtl/fifo_out_multi.sv | 108 ++++++++++
 tb/tb_fifo_out_multi.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_out_multi.sv
// Multi-lane write, single-lane AXI-Stream read FIFO with per-value TLAST and sticky overflow.
// The AXIS head lives in output registers; the storage array also keeps the head entry.
module fifo_out_multi #(
  parameter int OUTW  = 8,
  parameter int DEPTH = 12,
  parameter int LANES = 4,
  localparam int NW = $clog2(LANES + 1),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES*OUTW-1:0] data_in,
  input  logic                  wr_en,
  input  logic [NW-1:0]         wr_num,
  input  logic                  last_in,
  output logic [CW-1:0]         capacity,
  output logic                  overflow,
  output logic [OUTW-1:0]       AXIS_TDATA,
  output logic                  AXIS_TVALID,
  output logic                  AXIS_TLAST,
  input  logic                  AXIS_TREADY
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DEPTH + LANES) + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [OUTW:0]   mem [DEPTH];
  logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]   capacity_reg;
  logic            overflow_reg, tvalid_reg, tlast_reg;
  logic [OUTW-1:0] tdata_reg;

  logic            fire, legal;
  logic [CW-1:0]   occ, occ_after_read, occ_next;
  logic [PW-1:0]   rd_next, wr_next;
  logic [PW-1:0]   lane_pos  [LANES];
  logic            lane_we   [LANES];
  logic [OUTW:0]   lane_word [LANES];

  // Sums never reach 2*DEPTH because LANES <= DEPTH, so one subtraction wraps.
  function automatic logic [PW-1:0] wrap(input logic [SW-1:0] s);
    return (s >= DEPTH_S) ? PW'(s - DEPTH_S) : PW'(s);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_pos[gi]  = wrap(SW'(wr_ptr_reg) + SW'(gi));
      assign lane_we[gi]   = legal && (NW'(gi) < wr_num);
      assign lane_word[gi] = {last_in && (NW'(gi + 1) == wr_num), data_in[gi*OUTW +: OUTW]};
    end
  endgenerate

  always_comb begin
    fire           = tvalid_reg && AXIS_TREADY;
    occ            = DEPTH_C - capacity_reg;
    legal          = wr_en && (wr_num != '0) && (CW'(wr_num) <= capacity_reg);
    occ_after_read = occ - CW'(fire);
    occ_next       = occ_after_read + (legal ? CW'(wr_num) : '0);
    rd_next        = fire ? wrap(SW'(rd_ptr_reg) + SW'(1)) : rd_ptr_reg;
    wr_next        = legal ? wrap(SW'(wr_ptr_reg) + SW'(wr_num)) : wr_ptr_reg;
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (reset && lane_we[j]) mem[lane_pos[j]] <= lane_word[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      capacity_reg <= DEPTH_C;
      overflow_reg <= 1'b0;
      tvalid_reg   <= 1'b0;
      tlast_reg    <= 1'b0;
      tdata_reg    <= '0;
    end else begin
      rd_ptr_reg   <= rd_next;
      wr_ptr_reg   <= wr_next;
      capacity_reg <= DEPTH_C - occ_next;
      if (wr_en && !legal) overflow_reg <= 1'b1;
      // Reload the head only when it is consumed or absent; a new head written
      // this very edge can only be lane 0, since it was empty before.
      if (fire || !tvalid_reg) begin
        if (occ_after_read != '0) begin
          tvalid_reg               <= 1'b1;
          {tlast_reg, tdata_reg}   <= mem[rd_next];
        end else if (legal) begin
          tvalid_reg               <= 1'b1;
          {tlast_reg, tdata_reg}   <= lane_word[0];
        end else begin
          tvalid_reg               <= 1'b0;
        end
      end
    end
  end

  assign capacity    = capacity_reg;
  assign overflow    = overflow_reg;
  assign AXIS_TDATA  = tdata_reg;
  assign AXIS_TVALID = tvalid_reg;
  assign AXIS_TLAST  = tlast_reg;

endmodule

// File: tb/tb_fifo_out_multi.sv
// Directed bench for fifo_out_multi: queue model checked every cycle plus literal expectations.
module tb_fifo_out_multi;
  localparam int OUTW  = 8;
  localparam int DEPTH = 12;
  localparam int LANES = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [LANES*OUTW-1:0] data_in = '0;
  logic                  wr_en = 1'b0;
  logic [2:0]            wr_num = '0;
  logic                  last_in = 1'b0;
  logic [3:0]            capacity;
  logic                  overflow;
  logic [OUTW-1:0]       tdata;
  logic                  tvalid, tlast;
  logic                  tready = 1'b0;

  fifo_out_multi #(.OUTW(OUTW), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wr_en(wr_en), .wr_num(wr_num),
    .last_in(last_in), .capacity(capacity), .overflow(overflow),
    .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TLAST(tlast), .AXIS_TREADY(tready)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         chk_en = 0;
  logic [8:0] mq[$];
  bit         m_ovf = 0;
  logic [8:0] log_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue of {last,data}; legality uses occupancy before the edge.
  always @(posedge clk) begin : model
    int  sz;
    bit  fire, legal;
    if (reset && tvalid === 1'b1 && tready) begin
      log_q.push_back({tlast, tdata});
      $display("xfer data=%02h last=%0b", tdata, tlast);
    end
    if (!reset) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      sz    = mq.size();
      fire  = (sz > 0) && tready;
      legal = wr_en && (wr_num >= 1) && (int'(wr_num) <= DEPTH - sz);
      if (wr_en && !legal) m_ovf = 1;
      if (fire) void'(mq.pop_front());
      if (legal)
        for (int j = 0; j < int'(wr_num); j++)
          mq.push_back({last_in && (j == int'(wr_num) - 1), data_in[j*OUTW +: OUTW]});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tvalid", 32'(tvalid), 32'(mq.size() > 0));
      check("capacity", 32'(capacity), 32'(DEPTH - mq.size()));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (mq.size() > 0) begin
        check("tdata", 32'(tdata), 32'(mq[0][7:0]));
        check("tlast", 32'(tlast), 32'(mq[0][8]));
      end
    end
  end

  task automatic cyc(input bit we, input int n, input logic [31:0] d, input bit l, input bit rdy);
    wr_en   = we;
    wr_num  = 3'(n);
    data_in = d;
    last_in = l;
    tready  = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(0, 0, 0, 0, 0);
    reset = 1'b1;
    log_q.delete();
  endtask

  task automatic drain();
    int k = 0;
    while (mq.size() > 0 && k < 200) begin
      cyc(0, 0, 0, 0, 1);
      k++;
    end
    cyc(0, 0, 0, 0, 0);
    check("drain_timeout", 32'(mq.size()), 0);
  endtask

  function automatic logic [31:0] pack4(input int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  initial begin
    int idx, guard;
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1;
    check("rst_capacity", 32'(capacity), 12);
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset = 1'b1;

    // Single-lane stream with random back-pressure, never writing when full.
    idx = 0; guard = 0;
    while (idx < 100 && guard < 3000) begin
      if (mq.size() < DEPTH) begin
        cyc(1, 1, 32'(idx), 0, 1'($urandom_range(0, 1)));
        idx++;
      end else begin
        cyc(0, 0, 0, 0, 1'($urandom_range(0, 1)));
      end
      guard++;
    end
    drain();
    check("stream_count", 32'(log_q.size()), 100);
    for (int i = 0; i < 100 && i < log_q.size(); i++) check("stream_data", 32'(log_q[i][7:0]), 32'(i));
    check("stream_ovf", 32'(overflow), 0);
    check("stream_cap", 32'(capacity), 12);

    // Multi-lane fill to full, then an illegal write.
    do_reset();
    cyc(1, 4, pack4(8'h00), 0, 0); check("fill_cap1", 32'(capacity), 8);
    cyc(1, 4, pack4(8'h10), 0, 0); check("fill_cap2", 32'(capacity), 4);
    cyc(1, 4, pack4(8'h20), 0, 0); check("fill_cap3", 32'(capacity), 0);
    cyc(1, 1, 32'h99, 0, 0);
    check("full_ovf", 32'(overflow), 1);
    check("full_cap", 32'(capacity), 0);
    check("full_head", 32'(tdata), 0);
    drain();
    check("fill_count", 32'(log_q.size()), 12);
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++)
        if (k*4 + j < log_q.size()) check("fill_order", 32'(log_q[k*4+j][7:0]), 32'(16*k + j));

    // Wrap straddle: pointers to 10, then a 4-lane write across the wrap.
    do_reset();
    cyc(1, 4, pack4(8'h40), 0, 0);
    cyc(1, 4, pack4(8'h44), 0, 0);
    cyc(1, 2, pack4(8'h48), 0, 0);
    drain();
    log_q.delete();
    cyc(1, 4, 32'hDDCCBBAA, 0, 0);
    check("wrap_head", 32'(tdata), 32'hAA);
    drain();
    check("wrap_count", 32'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      check("wrap_a", 32'(log_q[0][7:0]), 32'hAA);
      check("wrap_b", 32'(log_q[1][7:0]), 32'hBB);
      check("wrap_c", 32'(log_q[2][7:0]), 32'hCC);
      check("wrap_d", 32'(log_q[3][7:0]), 32'hDD);
    end

    // Simultaneous read/write at capacity 1.
    do_reset();
    cyc(1, 4, pack4(8'h50), 0, 0);
    cyc(1, 4, pack4(8'h54), 0, 0);
    cyc(1, 3, pack4(8'h58), 0, 0);
    check("rw_cap_start", 32'(capacity), 1);
    cyc(1, 1, 32'h77, 0, 1);
    check("rw_cap_legal", 32'(capacity), 1);
    check("rw_ovf_legal", 32'(overflow), 0);
    check("rw_head", 32'(tdata), 32'h51);
    cyc(1, 2, 32'h8888, 0, 1);
    check("rw_cap_illegal", 32'(capacity), 2);
    check("rw_ovf_illegal", 32'(overflow), 1);
    drain();

    // TLAST marks only the highest written lane.
    do_reset();
    cyc(1, 3, pack4(8'h60), 1, 0);
    cyc(1, 2, pack4(8'h70), 0, 0);
    drain();
    check("tlast_count", 32'(log_q.size()), 5);
    if (log_q.size() == 5) begin
      check("tlast_seq", {27'd0, log_q[0][8], log_q[1][8], log_q[2][8], log_q[3][8], log_q[4][8]},
            32'b00100);
    end

    // Reset mid-stream discards 7 stored values and clears overflow.
    do_reset();
    cyc(1, 0, 0, 0, 0);
    check("mid_ovf_set", 32'(overflow), 1);
    cyc(1, 4, pack4(8'h80), 0, 0);
    cyc(1, 3, pack4(8'h84), 1, 0);
    check("mid_cap", 32'(capacity), 5);
    check("mid_tvalid", 32'(tvalid), 1);
    reset = 1'b0;
    cyc(0, 0, 0, 0, 1);
    reset = 1'b1;
    check("mid_rst_tvalid", 32'(tvalid), 0);
    check("mid_rst_cap", 32'(capacity), 12);
    check("mid_rst_ovf", 32'(overflow), 0);
    cyc(1, 1, 32'h05, 0, 0);
    check("mid_first_valid", 32'(tvalid), 1);
    check("mid_first_data", 32'(tdata), 5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
